// File: rtl/rate_sequencer_pkg.sv
// Shared constants and state type for the rate sequencer and its limit table.
// CLK_MAX_WIDTH mirrors the divider's limit width.
package rate_sequencer_pkg;

    localparam int unsigned CLK_MAX_WIDTH       = 16;
    localparam int unsigned DEFAULT_RESET_LIMIT = 50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        STEP1 = 2'd3
    } seq_state_t;

endpackage

// File: rtl/rate_sequencer_table.sv
// Divide-limit table: ENTRIES x WIDTH registers.
// Synchronous write, asynchronous read, synchronous active-low reset.
module rate_table
    import rate_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH       = CLK_MAX_WIDTH,
    parameter int unsigned ENTRIES     = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned RESET_LIMIT = DEFAULT_RESET_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem[i] <= WIDTH'(RESET_LIMIT);
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Same-cycle write and read of one entry returns the old contents.
    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/rate_sequencer.sv
// Steps the clock divider through a table of limits, dwelling on each entry
// for a programmed number of divider output rising edges.
module rate_sequencer
    import rate_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH       = CLK_MAX_WIDTH,
    parameter int unsigned ENTRIES     = 4,
    parameter int unsigned IDX_W       = 2,
    parameter int unsigned DWELL_W     = 16,
    parameter int unsigned RESET_LIMIT = DEFAULT_RESET_LIMIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [WIDTH-1:0]   wr_limit,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               div_clk,
    output logic [WIDTH-1:0]   limit,
    output logic               limit_ld,
    output logic [IDX_W-1:0]   idx,
    output logic               busy,
    output logic               err
);

    seq_state_t         state, state_n;
    logic [IDX_W-1:0]   idx_n;
    logic [WIDTH-1:0]   limit_n;
    logic               ld_n;
    logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
    logic [IDX_W:0]     skip_cnt, skip_n;
    logic               err_n;
    logic               ret, ret_n;
    logic               div_clk_q;
    logic               div_rise;
    logic [WIDTH-1:0]   entry;
    logic [DWELL_W-1:0] dwell_last;

    rate_table #(
        .WIDTH      (WIDTH),
        .ENTRIES    (ENTRIES),
        .IDX_W      (IDX_W),
        .RESET_LIMIT(RESET_LIMIT)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_idx (wr_idx),
        .wr_data(wr_limit),
        .rd_idx (idx),
        .rd_data(entry)
    );

    assign div_rise   = div_clk & ~div_clk_q;
    assign dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    assign busy       = (state == LOAD) || (state == RUN);

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        limit_n     = limit;
        ld_n        = 1'b0;
        dwell_cnt_n = dwell_cnt;
        skip_n      = skip_cnt;
        err_n       = err;
        ret_n       = ret;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n = LOAD;
                    err_n   = 1'b0;
                    skip_n  = '0;
                end else if (step && !start) begin
                    state_n = STEP1;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_n     = IDLE;
                    dwell_cnt_n = '0;
                    skip_n      = '0;
                    ret_n       = 1'b0;
                end else if (entry != '0) begin
                    limit_n     = entry;
                    ld_n        = 1'b1;
                    dwell_cnt_n = '0;
                    skip_n      = '0;
                    ret_n       = 1'b0;
                    state_n     = ret ? IDLE : RUN;
                end else begin
                    // Zero entries are skipped; a full lap of them is an error.
                    idx_n = idx + IDX_W'(1);
                    if (skip_cnt == (IDX_W+1)'(ENTRIES - 1)) begin
                        err_n   = 1'b1;
                        skip_n  = '0;
                        ret_n   = 1'b0;
                        state_n = IDLE;
                    end else begin
                        skip_n = skip_cnt + (IDX_W+1)'(1);
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_n     = IDLE;
                    dwell_cnt_n = '0;
                end else if (div_rise) begin
                    // >= so a dwell lowered below the count advances on the next edge.
                    if (dwell_cnt >= dwell_last) begin
                        idx_n       = idx + IDX_W'(1);
                        dwell_cnt_n = '0;
                        state_n     = LOAD;
                    end else begin
                        dwell_cnt_n = dwell_cnt + DWELL_W'(1);
                    end
                end
            end
            STEP1: begin
                if (stop) begin
                    state_n     = IDLE;
                    dwell_cnt_n = '0;
                end else begin
                    idx_n   = idx + IDX_W'(1);
                    ret_n   = 1'b1;
                    state_n = LOAD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            limit     <= WIDTH'(RESET_LIMIT);
            limit_ld  <= 1'b0;
            dwell_cnt <= '0;
            skip_cnt  <= '0;
            err       <= 1'b0;
            ret       <= 1'b0;
            div_clk_q <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            limit     <= limit_n;
            limit_ld  <= ld_n;
            dwell_cnt <= dwell_cnt_n;
            skip_cnt  <= skip_n;
            err       <= err_n;
            ret       <= ret_n;
            div_clk_q <= div_clk;
        end
    end

endmodule

// File: tb/tb_rate_sequencer.sv
// Self-checking bench for rate_sequencer: directed scenarios plus randomized
// tables and dwells, checked against a table-walking reference model.
module tb_rate_sequencer;
    import rate_sequencer_pkg::*;

    localparam int unsigned WIDTH   = CLK_MAX_WIDTH;
    localparam int unsigned ENTRIES = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned DWELL_W = 16;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic               step;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [WIDTH-1:0]   wr_limit;
    logic [DWELL_W-1:0] dwell;
    logic               div_clk;
    logic [WIDTH-1:0]   limit;
    logic               limit_ld;
    logic [IDX_W-1:0]   idx;
    logic               busy;
    logic               err;

    int n_assert = 0;
    int n_fail   = 0;
    int ld_count = 0;

    int tab [ENTRIES];
    int m_idx;
    int m_limit;
    int m_loads;
    int m_err;

    rate_sequencer #(
        .WIDTH      (WIDTH),
        .ENTRIES    (ENTRIES),
        .IDX_W      (IDX_W),
        .DWELL_W    (DWELL_W),
        .RESET_LIMIT(50)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .step    (step),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_limit(wr_limit),
        .dwell   (dwell),
        .div_clk (div_clk),
        .limit   (limit),
        .limit_ld(limit_ld),
        .idx     (idx),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (limit_ld === 1'b1) ld_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int next_nz(input int from);
        int i;
        for (int k = 0; k < ENTRIES; k++) begin
            i = (from + k) % ENTRIES;
            if (tab[i] != 0) return i;
        end
        return -1;
    endfunction

    // A load walks forward from 'from' to the first non-zero entry.
    task automatic m_load(input int from);
        int i;
        i = next_nz(from);
        if (i < 0) begin
            m_err = 1;
            m_idx = from % ENTRIES;
        end else begin
            m_idx   = i;
            m_limit = tab[i];
            m_loads++;
        end
    endtask

    function automatic int eff_dwell();
        return (dwell == '0) ? 1 : int'(dwell);
    endfunction

    task automatic settle();
        repeat (6) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
        wr_en = 1'b0; div_clk = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < ENTRIES; i++) tab[i] = 50;
        m_idx = 0; m_limit = 50; m_err = 0;
        tick();
        m_loads = ld_count;
    endtask

    task automatic wr(input int i, input int v);
        wr_en = 1'b1; wr_idx = IDX_W'(i); wr_limit = WIDTH'(v);
        tick();
        wr_en = 1'b0;
        tab[i] = v;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        settle();
        m_err = 0;
        m_load(m_idx);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic edge1();
        repeat ($urandom_range(0, 2)) tick();
        div_clk = 1'b1;
        tick();
        div_clk = 1'b0;
        tick();
    endtask

    task automatic advance();
        repeat (eff_dwell()) edge1();
        settle();
        m_load(m_idx + 1);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_limit"}, 32'(limit), m_limit);
        chk({tag, "_idx"}, 32'(idx), m_idx);
        chk({tag, "_ldcnt"}, ld_count, m_loads);
        chk({tag, "_err"}, 32'(err), m_err);
    endtask

    initial begin
        int base;
        int old_lim;
        rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_limit = '0; dwell = DWELL_W'(3); div_clk = 1'b0;

        // Reset values, then reset in the middle of a run.
        do_reset();
        chk("rst_limit", 32'(limit), 50);
        chk("rst_idx", 32'(idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ld", 32'(limit_ld), 0);
        do_start();
        chk("rst_tab_default", 32'(limit), 50);
        chk("rst_busy_run", 32'(busy), 1);
        wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
        dwell = DWELL_W'(1);
        advance();
        advance();
        check_model("pre_rst");
        settle();
        base = ld_count;
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_limit", 32'(limit), 50);
        chk("midrst_idx", 32'(idx), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(err), 0);
        rst = 1'b1;
        tick();
        chk("midrst_ld", 32'(limit_ld), 0);
        chk("midrst_ldcnt", ld_count, base);
        do_reset();
        do_start();
        chk("midrst_tab_reset", 32'(limit), 50);

        // Auto sequencing with dwell 3, including the two-cycle update latency.
        do_reset();
        wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
        dwell = DWELL_W'(3);
        do_start();
        check_model("auto_first");
        chk("auto_busy", 32'(busy), 1);
        for (int n = 0; n < 5; n++) begin
            old_lim = m_limit;
            edge1();
            edge1();
            chk("auto_hold", 32'(limit), old_lim);
            repeat ($urandom_range(0, 2)) tick();
            div_clk = 1'b1;
            tick();
            chk("auto_lat1", 32'(limit), old_lim);
            div_clk = 1'b0;
            tick();
            m_load(m_idx + 1);
            chk("auto_lat2", 32'(limit), m_limit);
            chk("auto_ld_pulse", 32'(limit_ld), 1);
            tick();
            chk("auto_ld_single", 32'(limit_ld), 0);
            check_model("auto");
        end

        // Skip markers, then an all-zero table.
        do_reset();
        wr(0, 10); wr(1, 0); wr(2, 0); wr(3, 40);
        dwell = DWELL_W'(1);
        do_start();
        check_model("skip0");
        advance();
        check_model("skip1");
        chk("skip1_limit40", 32'(limit), 40);
        advance();
        check_model("skip2");
        do_stop();
        wr(0, 0); wr(3, 0);
        do_start();
        check_model("allzero");
        chk("allzero_err", 32'(err), 1);
        chk("allzero_busy", 32'(busy), 0);
        wr(2, 7);
        do_start();
        check_model("err_clear");

        // Single steps from IDLE, stop beating start, step ignored while running.
        do_reset();
        wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
        for (int n = 0; n < 2; n++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            settle();
            m_load(m_idx + 1);
            check_model("step");
        end
        chk("step_idx2", 32'(idx), 2);
        chk("step_busy", 32'(busy), 0);
        do_start();
        check_model("step_start");
        chk("step_run_busy", 32'(busy), 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        settle();
        check_model("step_in_run");
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        tick();
        chk("stopstart_busy", 32'(busy), 0);
        check_model("stopstart");

        // A write to the applied entry waits for its next load.
        do_reset();
        wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
        dwell = DWELL_W'(1);
        do_start();
        advance();
        chk("wh_on20", 32'(limit), 20);
        wr(1, 99);
        settle();
        chk("wh_snapshot", 32'(limit), 20);
        for (int n = 0; n < 4; n++) begin
            advance();
            check_model("wh");
        end
        chk("wh_new99", 32'(limit), 99);

        // Dwell 0 acts as 1; lowering dwell below the count advances on the next edge.
        dwell = '0;
        advance();
        check_model("dw0_a");
        advance();
        check_model("dw0_b");
        dwell = DWELL_W'(5);
        edge1(); edge1(); edge1();
        settle();
        check_model("dw5_hold");
        dwell = DWELL_W'(2);
        edge1();
        settle();
        m_load(m_idx + 1);
        check_model("dw_lowered");

        // Randomized tables and dwells.
        for (int it = 0; it < 6; it++) begin
            do_stop();
            for (int i = 0; i < ENTRIES; i++) begin
                wr(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 1000)));
            end
            if (next_nz(0) < 0) wr(int'($urandom_range(0, ENTRIES - 1)), 123);
            dwell = DWELL_W'($urandom_range(0, 3));
            do_start();
            check_model("rnd_start");
            repeat (4) begin
                advance();
                check_model("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
